operand_queue: RTL and testbench
================================

# operand_queue

Parametrised operand collector, the successor to the fixed three-register accumulator. It sits between the decode stage and the execute stage. Each put instruction appends an operand to the next free slot. An op instruction consumes all slots. The block acts at most once per distinct program-counter value, so instructions that take several cycles are not applied more than once.

## Interface
Parameters:
- WIDTH, 8, operand width in bits
- DEPTH, 3, number of operand slots (≥1)
- PC_WIDTH, 12, program-counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- put_en  input  1  append `value` to the queue
- op_en  input  1  consume (clear) the queue
- value  input  WIDTH  operand to append
- prog_ctr  input  PC_WIDTH  current program counter; qualifies events
- operands  output  DEPTH*WIDTH  slot i at bits [i*WIDTH +: WIDTH]
- valid  output  DEPTH  per-slot valid; always thermometer (slots 0..count-1 set)
- count  output  $clog2(DEPTH+1)  number of valid slots
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a put arrived while full

## Operation
- **Event qualification:** an edge is an *event edge* when `pc_seen` is 0 (first edge after reset) or `prog_ctr` differs from `last_pc`.
  - On every event edge, `last_pc` ← `prog_ctr` and `pc_seen` ← 1.
  - On all other edges, state holds regardless of `put_en`/`op_en`.
- **Commands on an event edge:**
  - put only, not full: `operands[count]` ← `value`; `valid[count]` ← 1; count+1.
  - put only, full: the queue follows the full-queue policy (see Configuration); `overflow` ← 1.
  - op only: all `valid` ← 0; count ← 0; `overflow` ← 0. Slot data is retained but is meaningless.
  - put and op together (consume-and-load): the queue clears; slot 0 ← `value`; count ← 1; `overflow` ← 0.
  - neither: no change, but `last_pc` still updates.
- **Derived outputs:** `full`, `empty` and `valid` are decoded from the registered `count`. They never disagree with `count`.
- **Reset:**
  - count = 0, valid = 0, operands = 0, overflow = 0, full = 0, empty = 1, pc_seen = 0, last_pc = 0.
  - Reset overrides any command on the same edge, including in the middle of an accumulation.

## Timing
- All outputs are registered. A command on edge N is visible after edge N; the latency is one cycle.
- One command is executed per distinct `prog_ctr` value. Holding `prog_ctr` for k cycles with `put_en` high appends exactly once.
- Consecutive different PC values on consecutive cycles are each events, so the block can append one operand per cycle.
- A PC that returns to an earlier value, such as a loop, is still an event whenever it differs from the immediately previous value.
- `value` is sampled only on the event edge. Changes to `value` on non-event cycles are ignored.

## Configuration
- Macro: `OPERAND_QUEUE_SHIFT_EN`.
- **Defined:** a put while full shifts the queue.
  - Slot i ← slot i+1 for i < DEPTH-1; slot DEPTH-1 ← `value`.
  - count stays DEPTH; `overflow` ← 1.
  - Net effect: the queue keeps the newest DEPTH operands.
- **Undefined:** a put while full is dropped. Slots and count are unchanged; `overflow` ← 1.

## Test plan
- **Basic fill (DEPTH=3):** reset, then put 5, 6, 7 on PCs 1, 2, 3.
  - Expect operands = {7, 6, 5}, valid = 3'b111, count = 3, full = 1, overflow = 0.
- **Held PC:** hold PC = 4 for 5 cycles with put_en = 1, value = 9.
  - Expect count to increment exactly once. Changing value on cycles 2–5 does not alter slot 0.
- **Overflow:** from a full queue {7, 6, 5}, put 8 on PC = 5.
  - Without the macro: operands unchanged, overflow = 1.
  - With `OPERAND_QUEUE_SHIFT_EN`: operands = {8, 7, 6}, overflow = 1.
- **Op and consume-and-load:** with a full queue, op on PC = 6 gives count = 0, empty = 1, overflow = 0. Then put_en = op_en = 1 with value = 3 on PC = 7 gives count = 1, slot 0 = 3, valid = 3'b001.
- **Reset mid-operation:** with count = 2, assert rst_n = 0 on a new-PC edge with put_en = 1.
  - Expect all outputs at reset values.
  - The first edge after release with unchanged PC still counts as an event.
- **Parametric:** WIDTH = 16, DEPTH = 5. Put 0xFFFF, 0x0001, 0x8000, 0x1234, 0xABCD, then a sixth put.
  - Expect slots 0–4 to match in order, and count = 5 with full = 1 after the fifth put.
  - The sixth put sets overflow = 1.

Source files
------------

// File: rtl/operand_queue.sv
// Operand collector: put appends to the next free slot, op clears; acts once per distinct PC.
// Optional OPERAND_QUEUE_SHIFT_EN: a put while full shifts out the oldest slot instead of dropping.
module operand_queue #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int PC_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       put_en,
    input  logic                       op_en,
    input  logic [WIDTH-1:0]           value,
    input  logic [PC_WIDTH-1:0]        prog_ctr,
    output logic [DEPTH*WIDTH-1:0]     operands,
    output logic [DEPTH-1:0]           valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0]    slot_reg  [DEPTH];
    logic [WIDTH-1:0]    slot_next [DEPTH];
    logic [CW-1:0]       count_reg, count_next;
    logic                overflow_reg, overflow_next;
    logic [PC_WIDTH-1:0] last_pc_reg;
    logic                pc_seen_reg;
    logic                pc_event;
    logic                full_now;

    // A multi-cycle instruction holds its PC, so only a PC change (or the first edge) acts.
    assign pc_event = !pc_seen_reg || (prog_ctr != last_pc_reg);
    assign full_now = (count_reg == CW'(DEPTH));

    always_comb begin
        slot_next     = slot_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (pc_event) begin
            if (put_en && op_en) begin
                slot_next[0]  = value;
                count_next    = CW'(1);
                overflow_next = 1'b0;
            end else if (op_en) begin
                count_next    = '0;
                overflow_next = 1'b0;
            end else if (put_en) begin
                if (!full_now) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (count_reg == CW'(i)) begin
                            slot_next[i] = value;
                        end
                    end
                    count_next = count_reg + CW'(1);
                end else begin
                    overflow_next = 1'b1;
`ifdef OPERAND_QUEUE_SHIFT_EN
                    for (int i = 0; i < DEPTH-1; i++) begin
                        slot_next[i] = slot_reg[i+1];
                    end
                    slot_next[DEPTH-1] = value;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            last_pc_reg  <= '0;
            pc_seen_reg  <= 1'b0;
        end else begin
            slot_reg     <= slot_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            if (pc_event) begin
                last_pc_reg <= prog_ctr;
                pc_seen_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign operands[gi*WIDTH +: WIDTH] = slot_reg[gi];
            assign valid[gi]                   = (count_reg > CW'(gi));
        end
    endgenerate

    assign count    = count_reg;
    assign full     = full_now;
    assign empty    = (count_reg == '0);
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_operand_queue.sv
// Drives two operand_queue instances (8x3 and 16x5) with identical stimulus and
// compares both against a queue-based reference model after every edge.
module tb_operand_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        put_en = 1'b0;
    logic        op_en = 1'b0;
    logic [15:0] value = '0;
    logic [11:0] prog_ctr = '0;

    logic [23:0] opa;
    logic [2:0]  va;
    logic [1:0]  ca;
    logic        fa, ea, ova;
    logic [79:0] opb;
    logic [4:0]  vb;
    logic [2:0]  cb;
    logic        fb, eb, ovb;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // reference model
    logic [7:0]  qa[$];
    logic [15:0] qb[$];
    logic        ova_m = 1'b0, ovb_m = 1'b0;
    logic        seen_m = 1'b0;
    logic [11:0] last_m = '0;

    operand_queue #(.WIDTH(8), .DEPTH(3), .PC_WIDTH(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .put_en(put_en), .op_en(op_en),
        .value(value[7:0]), .prog_ctr(prog_ctr), .operands(opa), .valid(va),
        .count(ca), .full(fa), .empty(ea), .overflow(ova)
    );

    operand_queue #(.WIDTH(16), .DEPTH(5), .PC_WIDTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .put_en(put_en), .op_en(op_en),
        .value(value), .prog_ctr(prog_ctr), .operands(opb), .valid(vb),
        .count(cb), .full(fb), .empty(eb), .overflow(ovb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [11:0] pc, input logic p,
                              input logic o, input logic [15:0] v);
        if (!r) begin
            qa.delete(); qb.delete();
            ova_m = 1'b0; ovb_m = 1'b0; seen_m = 1'b0; last_m = '0;
        end else if (!seen_m || pc != last_m) begin
            seen_m = 1'b1;
            last_m = pc;
            if (p && o) begin
                qa = {v[7:0]}; qb = {v};
                ova_m = 1'b0; ovb_m = 1'b0;
            end else if (o) begin
                qa.delete(); qb.delete();
                ova_m = 1'b0; ovb_m = 1'b0;
            end else if (p) begin
                if (qa.size() < 3) qa.push_back(v[7:0]);
                else begin
                    ova_m = 1'b1;
`ifdef OPERAND_QUEUE_SHIFT_EN
                    void'(qa.pop_front()); qa.push_back(v[7:0]);
`endif
                end
                if (qb.size() < 5) qb.push_back(v);
                else begin
                    ovb_m = 1'b1;
`ifdef OPERAND_QUEUE_SHIFT_EN
                    void'(qb.pop_front()); qb.push_back(v);
`endif
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_count", ca, qa.size());
        chk("a_full", fa, qa.size() == 3);
        chk("a_empty", ea, qa.size() == 0);
        chk("a_valid", va, (1 << qa.size()) - 1);
        chk("a_overflow", ova, ova_m);
        for (int i = 0; i < qa.size(); i++) chk("a_slot", opa[i*8 +: 8], qa[i]);
        chk("b_count", cb, qb.size());
        chk("b_full", fb, qb.size() == 5);
        chk("b_empty", eb, qb.size() == 0);
        chk("b_valid", vb, (1 << qb.size()) - 1);
        chk("b_overflow", ovb, ovb_m);
        for (int i = 0; i < qb.size(); i++) chk("b_slot", opb[i*16 +: 16], qb[i]);
    endtask

    task automatic step(input logic r, input logic [11:0] pc, input logic p,
                        input logic o, input logic [15:0] v);
        rst_n = r; prog_ctr = pc; put_en = p; op_en = o; value = v;
        @(posedge clk);
        model_edge(r, pc, p, o, v);
        #1;
        check_all();
    endtask

    initial begin
        // reset
        step(0, 12'd0, 0, 0, 16'd0);
        step(0, 12'd0, 1, 0, 16'd99);
        chk("rst_ops_a", opa, 0);
        chk("rst_ops_b", opb, 0);
        chk("rst_empty_a", ea, 1'b1);

        // basic fill
        step(1, 12'd1, 1, 0, 16'd5);
        step(1, 12'd2, 1, 0, 16'd6);
        step(1, 12'd3, 1, 0, 16'd7);
        chk("fill_ops_a", opa, 24'h070605);
        chk("fill_full_a", fa, 1'b1);

        // held PC appends once; later value changes ignored
        step(1, 12'd4, 0, 1, 16'd0);
        for (int k = 0; k < 5; k++) step(1, 12'd5, 1, 0, 16'(9 + k));
        chk("held_cnt_a", ca, 2'd1);
        chk("held_slot0_a", opa[7:0], 8'd9);

        // overflow from full {7,6,5}
        step(1, 12'd6, 0, 1, 16'd0);
        step(1, 12'd7, 1, 0, 16'd5);
        step(1, 12'd8, 1, 0, 16'd6);
        step(1, 12'd9, 1, 0, 16'd7);
        step(1, 12'd10, 1, 0, 16'd8);
`ifdef OPERAND_QUEUE_SHIFT_EN
        chk("ovf_ops_a", opa, 24'h080706);
`else
        chk("ovf_ops_a", opa, 24'h070605);
`endif
        chk("ovf_flag_a", ova, 1'b1);

        // op, then consume-and-load
        step(1, 12'd11, 0, 1, 16'd0);
        chk("op_empty_a", ea, 1'b1);
        chk("op_ovf_a", ova, 1'b0);
        step(1, 12'd12, 1, 1, 16'd3);
        chk("cal_valid_a", va, 3'b001);
        chk("cal_slot0_a", opa[7:0], 8'd3);

        // reset mid-accumulation, then first edge after release at PC 0
        step(1, 12'd13, 1, 0, 16'd21);
        step(1, 12'd14, 1, 0, 16'd22);
        step(0, 12'd15, 1, 0, 16'd23);
        chk("midrst_ops_a", opa, 0);
        chk("midrst_cnt_a", ca, 2'd0);
        step(0, 12'd0, 0, 0, 16'd0);
        step(1, 12'd0, 1, 0, 16'h44);
        chk("first_evt_cnt_a", ca, 2'd1);
        chk("first_evt_slot_a", opa[7:0], 8'h44);

        // parametric 16x5
        step(1, 12'd20, 0, 1, 16'd0);
        step(1, 12'd21, 1, 0, 16'hFFFF);
        step(1, 12'd22, 1, 0, 16'h0001);
        step(1, 12'd23, 1, 0, 16'h8000);
        step(1, 12'd24, 1, 0, 16'h1234);
        step(1, 12'd25, 1, 0, 16'hABCD);
        chk("par_ops_b", opb, 80'hABCD_1234_8000_0001_FFFF);
        chk("par_cnt_b", cb, 3'd5);
        chk("par_full_b", fb, 1'b1);
        chk("par_ovf_pre_b", ovb, 1'b0);
        step(1, 12'd26, 1, 0, 16'h5555);
        chk("par_ovf_b", ovb, 1'b1);

        // randomized: small PC range for frequent holds and revisits
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 40) != 0, 12'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
